// File: rtl/ray_aabb_err_monitor.sv
// On-chip hit/miss checker for the Ray_AABB pipeline: delays golden hit bits by LATENCY and counts Type1/Type2 errors.
// Optional first-mismatch capture ports are enabled by defining RAABB_FIRST_ERR_EN.
module ray_aabb_err_monitor #(
  parameter int LATENCY  = 42,
  parameter int NUM_RAYS = 10000,
  parameter int CNT_W    = 16,
  parameter int T1_W     = 10,
  parameter int T2_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             issue_valid,
  input  logic             issue_ref,
  input  logic             hit_miss,
  output logic             busy,
  output logic             done,
  output logic [T1_W-1:0]  type1_err,
  output logic [T2_W-1:0]  type2_err,
  output logic [CNT_W-1:0] checked_cnt,
`ifdef RAABB_FIRST_ERR_EN
  output logic [CNT_W-1:0] first_err_idx,
  output logic             first_err_type,
  output logic             first_err_valid,
`endif
  output logic             sat
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] NUM_RAYS_C = CNT_W'(NUM_RAYS);
  localparam logic [T1_W-1:0]  T1_MAX     = '1;
  localparam logic [T2_W-1:0]  T2_MAX     = '1;
  localparam logic [T1_W-1:0]  T1_NEAR    = T1_MAX - T1_W'(1);
  localparam logic [T2_W-1:0]  T2_NEAR    = T2_MAX - T2_W'(1);

  state_t             state, state_nxt;
  logic [LATENCY-1:0] dl_valid, dl_ref;
  logic [CNT_W-1:0]   issued_cnt, checked_nxt;
  logic               start_run, accept, cmp_en, cmp_ref, t1_hit, t2_hit;

  always_comb begin
    start_run   = start && (state != RUN);
    accept      = (state == RUN) && issue_valid && (issued_cnt < NUM_RAYS_C);
    cmp_en      = (state == RUN) && dl_valid[LATENCY-1];
    cmp_ref     = dl_ref[LATENCY-1];
    t1_hit      = cmp_en && cmp_ref && !hit_miss;
    t2_hit      = cmp_en && !cmp_ref && hit_miss;
    checked_nxt = checked_cnt + CNT_W'(cmp_en);
  end

  // Leaving RUN looks at the post-compare count so done rises right after the final compare.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (checked_nxt == NUM_RAYS_C) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dl_valid    <= '0;
      dl_ref      <= '0;
      issued_cnt  <= '0;
      checked_cnt <= '0;
      type1_err   <= '0;
      type2_err   <= '0;
      sat         <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_run) begin
        dl_valid    <= '0;
        dl_ref      <= '0;
        issued_cnt  <= '0;
        checked_cnt <= '0;
        type1_err   <= '0;
        type2_err   <= '0;
        sat         <= 1'b0;
      end else if (state == RUN) begin
        for (int i = LATENCY - 1; i > 0; i--) begin
          dl_valid[i] <= dl_valid[i-1];
          dl_ref[i]   <= dl_ref[i-1];
        end
        dl_valid[0] <= accept;
        dl_ref[0]   <= accept && issue_ref;
        if (accept) issued_cnt <= issued_cnt + CNT_W'(1);
        checked_cnt <= checked_nxt;
        // Error counters stick at all-ones; sat latches on the increment that gets there.
        if (t1_hit && (type1_err != T1_MAX)) begin
          type1_err <= type1_err + T1_W'(1);
          if (type1_err == T1_NEAR) sat <= 1'b1;
        end
        if (t2_hit && (type2_err != T2_MAX)) begin
          type2_err <= type2_err + T2_W'(1);
          if (type2_err == T2_NEAR) sat <= 1'b1;
        end
      end
    end
  end

`ifdef RAABB_FIRST_ERR_EN
  // Index is the pre-increment compare count of the first mismatching ray.
  always_ff @(posedge clk) begin
    if (rst || start_run) begin
      first_err_idx   <= '0;
      first_err_type  <= 1'b0;
      first_err_valid <= 1'b0;
    end else if ((t1_hit || t2_hit) && !first_err_valid) begin
      first_err_idx   <= checked_cnt;
      first_err_type  <= t2_hit;
      first_err_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/ray_aabb_err_monitor.md
Name: ray_aabb_err_monitor

Overview:
- Synthesizable on-chip result checker at the output end of the Ray_AABB_11_15 pipeline.
- Captures the golden (high-precision) hit bit for each ray as the ray is issued, and delays it by the pipeline latency.
- Compares the delayed golden bit with hit_miss and counts Type1 errors (golden hit, pipeline miss) and Type2 errors (golden miss, pipeline hit).
- Replaces the simulation-only scoreboard so error statistics can be read back from FPGA runs.

Parameters:
- LATENCY, 42, pipeline latency in cycles from ray issue to valid hit_miss; must be at least 1.
- NUM_RAYS, 10000, number of rays checked per run.
- CNT_W, 16, width of issue and check counters; must satisfy 2^CNT_W > NUM_RAYS.
- T1_W, 10, Type1 counter width.
- T2_W, 16, Type2 counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  pulse; begins a run from IDLE or DONE
- issue_valid  in  1  a ray enters the Ray_AABB pipeline this cycle
- issue_ref  in  1  golden hit bit for the ray issued this cycle
- hit_miss  in  1  pipeline result
- busy  out  1  high in RUN
- done  out  1  high in DONE
- type1_err  out  T1_W  saturating Type1 count
- type2_err  out  T2_W  saturating Type2 count
- checked_cnt  out  CNT_W  number of results compared
- sat  out  1  sticky; either error counter hit its all-ones value

Behaviour:
- Reset clears all state in one cycle: state = IDLE, delay line valid bits all 0, all counters 0, and busy, done and sat all 0. Reset has the same effect mid-run; no partial results are retained.
- State machine:
  - IDLE: start -> RUN and clear counters.
  - RUN: checked_cnt == NUM_RAYS -> DONE.
  - DONE: hold all outputs; start -> RUN and clear counters, sat and the delay line.
  - start while in RUN is ignored.
- Issue acceptance: only in RUN, and only while issued_cnt < NUM_RAYS (issued_cnt is internal). When a ray is accepted, the pair {1, issue_ref} enters stage 0 of a LATENCY-deep delay line. Otherwise {0, x} enters stage 0.
  - issue_valid in the same cycle as the accepting start is ignored. The first accepted ray is the one in the first cycle with busy = 1.
  - issue_valid beyond NUM_RAYS is dropped.
- Alignment: a ray accepted at posedge N is compared against hit_miss sampled at posedge N + LATENCY. The delay line shifts every cycle in RUN.
- Compare, whenever the delay line output valid = 1:
  - checked_cnt increments.
  - ref = 1 and hit_miss = 0: type1_err increments.
  - ref = 0 and hit_miss = 1: type2_err increments.
- Saturation: each error counter holds at all-ones; sat is set on the increment that reaches all-ones and stays set until start or rst.
- done rises in the cycle after the compare that makes checked_cnt == NUM_RAYS. busy falls in that same cycle.
- Counters are registered outputs and update one cycle after the compared posedge.

Optional Feature:
- Macro: RAABB_FIRST_ERR_EN.
- When defined, adds two ports:
  - first_err_idx, out, CNT_W: the checked_cnt value (before increment) of the first mismatch in the run.
  - first_err_type, out, 1: 0 = Type1, 1 = Type2.
  - Plus first_err_valid, out, 1: sticky, set on the first mismatch.
- All three clear on rst and on start.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- LATENCY=4, NUM_RAYS=8; all refs 1, hit_miss always 1 -> done rises 4 cycles after the last issue; type1_err = 0, type2_err = 0, checked_cnt = 8.
- LATENCY=4, NUM_RAYS=8; refs 1,0,1,0,1,0,1,0; hit_miss forced 0 throughout -> type1_err = 4, type2_err = 0.
- T2_W=2, NUM_RAYS=8; all refs 0, hit_miss = 1 -> type2_err = 3, and sat = 1 after the third mismatch.
- Issue 12 valid rays with NUM_RAYS=8 -> only the first 8 are compared; checked_cnt = 8, done = 1. Start in DONE -> counters return to 0 and busy = 1 next cycle.
- Assert rst after 5 checks mid-run -> next cycle state is IDLE and all counters 0. A stale delay-line entry never produces a compare after the next start.
- With RAABB_FIRST_ERR_EN defined: the only mismatch at ray 5 is ref 0 / hit 1 -> first_err_idx = 5, first_err_type = 1, first_err_valid = 1.
